// File: rtl/daq_scan_apb.sv
// APB data-acquisition peripheral: scans the selected sensor channels with a settle delay,
// then queues channel-tagged samples in a result FIFO that firmware drains over APB.
module daq_scan_apb #(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [7:0]              PADDR,
    input  logic [31:0]             PWDATA,
    input  logic [3:0]              PSTRB,
    input  logic [N_CH-1:0][DW-1:0] SensorReadings,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    IRQ
);

    localparam int unsigned CHW = $clog2(N_CH);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned EW  = CHW + DW;

    localparam logic [7:0] AddrCtrl   = 8'h00;
    localparam logic [7:0] AddrChmask = 8'h04;
    localparam logic [7:0] AddrStatus = 8'h08;
    localparam logic [7:0] AddrClear  = 8'h0C;
    localparam logic [7:0] AddrResult = 8'h10;
    localparam logic [7:0] AddrIrqEn  = 8'h14;

    typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic                cont_q, cont_d;
    logic [7:0]          settle_q, settle_d;
    logic [N_CH-1:0]     chmask_q, chmask_d;
    logic [2:0]          irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       count_q, count_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];

    logic access, err, wr_ok, rd_ok;
    logic sel_ctrl, sel_chmask, sel_status, sel_clear, sel_result, sel_irq_en, hit;
    logic start_req, stop_req, clr_done, clr_ovf;
    logic full, empty, push_req, push, pop, done_set;
    logic nxt_found;
    logic [CHW-1:0] nxt_ch, first_ch;
    logic [EW-1:0] head;
    logic [31:0] rdata;

    // ---------------------------------------------------------------- APB decode
    assign access     = PSEL & PENABLE;
    assign sel_ctrl   = (PADDR == AddrCtrl);
    assign sel_chmask = (PADDR == AddrChmask);
    assign sel_status = (PADDR == AddrStatus);
    assign sel_clear  = (PADDR == AddrClear);
    assign sel_result = (PADDR == AddrResult);
    assign sel_irq_en = (PADDR == AddrIrqEn);
    assign hit = sel_ctrl | sel_chmask | sel_status | sel_clear | sel_result | sel_irq_en;

    assign err = access & (~hit | (PWRITE & (sel_status | sel_result)) | (~PWRITE & sel_clear));
    assign wr_ok = access & PWRITE & ~err;
    assign rd_ok = access & ~PWRITE & ~err;

    assign start_req = wr_ok & sel_ctrl & PSTRB[0] & PWDATA[0];
    assign stop_req  = wr_ok & sel_ctrl & PSTRB[0] & PWDATA[2];
    assign clr_done  = wr_ok & sel_clear & PSTRB[0] & PWDATA[1];
    assign clr_ovf   = wr_ok & sel_clear & PSTRB[0] & PWDATA[2];

    assign PREADY  = access;
    assign PSLVERR = err;

    always_comb begin
        cont_d   = cont_q;
        settle_d = settle_q;
        chmask_d = chmask_q;
        irq_en_d = irq_en_q;
        if (wr_ok && sel_ctrl) begin
            if (PSTRB[0]) cont_d = PWDATA[1];
            if (PSTRB[1]) settle_d = PWDATA[15:8];
        end
        if (wr_ok && sel_chmask) begin
            for (int i = 0; i < N_CH; i++) begin
                if (PSTRB[i/8]) chmask_d[i] = PWDATA[i];
            end
        end
        if (wr_ok && sel_irq_en && PSTRB[0]) irq_en_d = PWDATA[2:0];
    end

    // ---------------------------------------------------------------- channel search
    always_comb begin
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (chmask_q[i]) first_ch = CHW'(i);
        end
    end

    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = CHW'(i);
            end
        end
    end

    // ---------------------------------------------------------------- scan FSM
    // The channel load takes the SETTLE value including any write landing this same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        mask_d   = mask_q;
        done_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_req && (chmask_q != '0)) begin
                    state_d = StSettle;
                    mask_d  = chmask_q;
                    ch_d    = first_ch;
                    cnt_d   = settle_d;
                end
            end
            StSettle: begin
                if (cnt_q == 8'd0) state_d = StCapture;
                else cnt_d = cnt_q - 8'd1;
            end
            StCapture: begin
                if (nxt_found) begin
                    state_d = StSettle;
                    ch_d    = nxt_ch;
                    cnt_d   = settle_d;
                end else begin
                    done_set = 1'b1;
                    if (cont_q && (chmask_q != '0)) begin
                        state_d = StSettle;
                        mask_d  = chmask_q;
                        ch_d    = first_ch;
                        cnt_d   = settle_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A capture already in flight still pushes, but a stopped pass never reports done.
        if (stop_req) begin
            state_d  = StIdle;
            done_set = 1'b0;
        end
    end

    // ---------------------------------------------------------------- result FIFO
    assign full     = (count_q == LW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = rd_ok & sel_result & ~empty;
    assign push_req = (state_q == StCapture);
    assign push     = push_req & (~full | pop);
    assign head     = mem_q[rptr_q];

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + LW'(push) - LW'(pop);
        done_d  = done_set | (done_q & ~clr_done);
        ovf_d   = (push_req & full & ~pop) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge PCLK) begin
        if (push) mem_q[wptr_q] <= {ch_q, SensorReadings[ch_q]};
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ch_q     <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            settle_q <= '0;
            chmask_q <= '0;
            irq_en_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            settle_q <= settle_d;
            chmask_q <= chmask_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------------------------------------------------------- read mux and IRQ
    always_comb begin
        rdata = '0;
        case (PADDR)
            AddrCtrl: begin
                rdata[1]    = cont_q;
                rdata[15:8] = settle_q;
            end
            AddrChmask: rdata[N_CH-1:0] = chmask_q;
            AddrStatus: begin
                rdata[0]    = (state_q != StIdle);
                rdata[1]    = done_q;
                rdata[2]    = ovf_q;
                rdata[3]    = empty;
                rdata[4]    = full;
                rdata[14:8] = 7'(count_q);
            end
            AddrResult: begin
                if (!empty) begin
                    rdata[31]     = 1'b1;
                    rdata[27:24]  = 4'(head[EW-1:DW]);
                    rdata[DW-1:0] = head[DW-1:0];
                end
            end
            AddrIrqEn: rdata[2:0] = irq_en_q;
            default: ;
        endcase
    end

    assign PRDATA = rd_ok ? rdata : 32'h0;
    assign IRQ = (irq_en_q[0] & done_q) | (irq_en_q[1] & ovf_q) | (irq_en_q[2] & ~empty);

    logic unused_ok;
    assign unused_ok = ^{PWDATA[31:16], PSTRB[3:2]};

endmodule
